asm_test_monitor: RTL

Synthesizable, parametrised checkpoint monitor for the Riscv151 core. It snoops the register-file writeback port into a shadow register file. It then steps through a programmable table of WAIT/CHECK/END entries, and reports pass, fail or timeout with diagnostic values. It generalises the directed "wait for flag register, then check registers" assembly-test flow to arbitrary depth and runs unchanged in simulation or on the FPGA, where it drives LEDs and UART status.

---
 rtl/asm_test_monitor.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/asm_test_monitor.sv
// Checkpoint monitor for the Riscv151 core.
// Shadows register-file writebacks, then walks a programmable table of
// WAIT / CHECK / END entries and reports pass, fail or timeout together with
// the failing index, the observed value and the expected value.
module asm_test_monitor #(
    parameter  int XLEN           = 32,
    parameter  int DEPTH          = 16,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int IW             = $clog2(DEPTH),
    localparam int CW             = $clog2(TIMEOUT_CYCLES + 1),
    localparam int EW             = XLEN + 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_addr,
    input  logic [EW-1:0]   cfg_data,
    input  logic            start,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [IW-1:0]   fail_index,
    output logic [XLEN-1:0] fail_got,
    output logic [XLEN-1:0] fail_expected
);

    localparam logic [1:0]    K_END   = 2'b00;
    localparam logic [1:0]    K_WAIT  = 2'b01;
    localparam logic [1:0]    K_CHECK = 2'b10;
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_IX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [EW-1:0]     cfg_tbl_r [DEPTH];
    logic [XLEN-1:0]   shadow_r  [32];

    logic              busy_r, busy_s, done_r, done_s, pass_r, pass_s;
    logic              fail_r, fail_s, timeout_r, timeout_s;
    logic [IW-1:0]     fail_index_r, fail_index_s;
    logic [XLEN-1:0]   fail_got_r, fail_got_s, fail_expected_r, fail_expected_s;

    logic [EW-1:0]     entry_s;
    logic [1:0]        kind_s;
    logic [4:0]        idx_s;
    logic [XLEN-1:0]   val_s, got_s, bad_got_s;
    logic              match_s, last_s, adv_s, end_s, bad_s;

    // Entry fields of the current pointer and the shadow value it refers to
    assign entry_s = cfg_tbl_r[ptr_r];
    assign kind_s  = entry_s[XLEN+6:XLEN+5];
    assign idx_s   = entry_s[XLEN+4:XLEN];
    assign val_s   = entry_s[XLEN-1:0];
    assign got_s   = (idx_s == 5'd0) ? {XLEN{1'b0}} : shadow_r[idx_s];
    assign match_s = (got_s == val_s);
    assign last_s  = (ptr_r == LAST_IX);

    // Shadow register file: mirrors every CPU writeback except to x0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow_r[i] <= {XLEN{1'b0}};
        end else if (wb_en && (wb_addr != 5'd0)) begin
            shadow_r[wb_addr] <= wb_data;
        end
    end

    // Checkpoint table: cleared to END entries, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cfg_tbl_r[i] <= {EW{1'b0}};
        end else if (cfg_we && !busy_r) begin
            cfg_tbl_r[cfg_addr] <= cfg_data;
        end
    end

    // Decode the current entry into advance / finish / failure decisions
    always_comb begin
        adv_s     = 1'b0;
        end_s     = 1'b0;
        bad_s     = 1'b0;
        bad_got_s = got_s;
        case (kind_s)
            K_END:   end_s = 1'b1;
            K_WAIT:  adv_s = match_s;
            K_CHECK: begin
                adv_s = match_s;
                bad_s = !match_s;
            end
            default: begin
                bad_s     = 1'b1;
                bad_got_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Next-state and next-output logic of the run controller
    always_comb begin
        state_s         = state_r;
        ptr_s           = ptr_r;
        cnt_s           = cnt_r;
        busy_s          = busy_r;
        done_s          = done_r;
        pass_s          = pass_r;
        fail_s          = fail_r;
        timeout_s       = timeout_r;
        fail_index_s    = fail_index_r;
        fail_got_s      = fail_got_r;
        fail_expected_s = fail_expected_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s         = ST_RUN;
                    ptr_s           = {IW{1'b0}};
                    cnt_s           = {CW{1'b0}};
                    busy_s          = 1'b1;
                    done_s          = 1'b0;
                    pass_s          = 1'b0;
                    fail_s          = 1'b0;
                    timeout_s       = 1'b0;
                    fail_index_s    = {IW{1'b0}};
                    fail_got_s      = {XLEN{1'b0}};
                    fail_expected_s = {XLEN{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                cnt_s = cnt_r + CW'(1);
                if (cnt_r == TMO_VAL) begin
                    // Timeout wins over whatever the entry would have decided
                    state_s         = ST_DONE;
                    busy_s          = 1'b0;
                    done_s          = 1'b1;
                    fail_s          = 1'b1;
                    timeout_s       = 1'b1;
                    fail_index_s    = ptr_r;
                    fail_got_s      = got_s;
                    fail_expected_s = val_s;
                end else if (end_s || (adv_s && last_s)) begin
                    // Stepping past the last entry is an implicit END
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = 1'b1;
                end else if (bad_s) begin
                    state_s         = ST_DONE;
                    busy_s          = 1'b0;
                    done_s          = 1'b1;
                    fail_s          = 1'b1;
                    fail_index_s    = ptr_r;
                    fail_got_s      = bad_got_s;
                    fail_expected_s = val_s;
                end else if (adv_s) begin
                    ptr_s = ptr_r + IW'(1);
                end else begin
                    ptr_s = ptr_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Controller state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            ptr_r           <= {IW{1'b0}};
            cnt_r           <= {CW{1'b0}};
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            fail_r          <= 1'b0;
            timeout_r       <= 1'b0;
            fail_index_r    <= {IW{1'b0}};
            fail_got_r      <= {XLEN{1'b0}};
            fail_expected_r <= {XLEN{1'b0}};
        end else begin
            state_r         <= state_s;
            ptr_r           <= ptr_s;
            cnt_r           <= cnt_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            pass_r          <= pass_s;
            fail_r          <= fail_s;
            timeout_r       <= timeout_s;
            fail_index_r    <= fail_index_s;
            fail_got_r      <= fail_got_s;
            fail_expected_r <= fail_expected_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign fail          = fail_r;
    assign timeout       = timeout_r;
    assign fail_index    = fail_index_r;
    assign fail_got      = fail_got_r;
    assign fail_expected = fail_expected_r;

endmodule
